rr_grant_arbiter8: RTL and testbench
====================================

# rr_grant_arbiter8

Round-robin arbiter for eight requesters. It produces a registered 3-bit grant index with a valid flag. The index drives the 3-to-8 one-hot decoder directly downstream, which turns it into per-channel enables. Fairness comes from a rotating priority pointer, and a configurable hold limit stops any one requester from keeping the grant indefinitely.

## Interface
- MAX_HOLD, 16: maximum number of consecutive cycles one grant may stay valid. Legal range is 1..255.
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req  in  8  request vector; bit k = requester k.
- done  in  1  current grant holder releases; sampled only while gnt_valid=1.
- gnt_idx  out  3  index of the granted requester; registered.
- gnt_valid  out  1  gnt_idx is a live grant; registered.
- timeout  out  1  one-cycle pulse when a grant is revoked by the hold limit.

## Operation
- State machine has two states, IDLE and BUSY. Reset state is IDLE.
- Reset values:
  - gnt_idx=3'd0, gnt_valid=0, timeout=0.
  - Priority pointer ptr=3'd0.
  - Hold counter hold_cnt=0.
- IDLE, req=0: remain in IDLE. Outputs hold their values (gnt_idx keeps the last index, gnt_valid=0).
- IDLE, req≠0:
  - Select the first set bit scanning ptr, ptr+1, …, ptr+7, with indices wrapping mod 8.
  - Register the selected index into gnt_idx and set gnt_valid=1.
  - Clear hold_cnt and move to BUSY.
- BUSY:
  - gnt_idx is frozen.
  - hold_cnt increments each cycle and saturates at MAX_HOLD. Its width is 8 bits.
- BUSY release conditions, evaluated every cycle in this priority order:
  1. done=1.
  2. req[gnt_idx]=0, meaning the requester dropped its request.
  3. hold_cnt == MAX_HOLD-1, meaning this is the last permitted cycle. This condition also drives timeout=1 on the next cycle.
- On release:
  - ptr ← gnt_idx+1 mod 8 (7 wraps to 0).
  - gnt_valid ← 0.
  - Go to IDLE.
- Reset mid-grant: gnt_valid drops immediately (asynchronously), ptr returns to 0, and no timeout pulse is produced.
- If done and the timeout condition occur in the same cycle, done wins and timeout stays 0.
- Requests from other bits that change during BUSY have no effect on the current grant. They are arbitrated at the next IDLE evaluation.

## Timing
- Grant latency: req observed in IDLE at edge N gives gnt_valid=1 and a valid gnt_idx after edge N.
- Release latency: a release condition sampled at edge M gives gnt_valid=0 after edge M.
- Minimum of one cycle with gnt_valid=0 between consecutive grants, including when the same requester holds req continuously.
- Maximum grant length is exactly MAX_HOLD cycles of gnt_valid=1. With MAX_HOLD=1, every grant lasts one cycle and then times out, unless done is seen on that cycle.
- timeout is high for exactly the one cycle in which gnt_valid first reads 0 after a hold-limit release.
- Worst-case wait for a persistently requesting input is 7×(MAX_HOLD+1) cycles.
- gnt_idx changes only on the transition from IDLE to BUSY, so the downstream decoder output is glitch-free while gnt_valid=1.

## Test plan
- Reset then single request:
  - Release rst_n, drive req=8'h20.
  - Required: next cycle gnt_idx=5, gnt_valid=1.
  - Pulse done, then check gnt_valid=0 and internal ptr=6.
- Rotation:
  - Hold req=8'hFF and pulse done on every grant.
  - Required grant order is 0,1,2,3,4,5,6,7,0, with exactly one gnt_valid=0 cycle between grants.
- Wrap-around:
  - Set ptr=6 by granting 5 first, then drive req=8'h21.
  - Required: grant 0 is skipped only if bit 6/7 request; here gnt_idx=0, then the next grant is 5.
- Hold limit:
  - MAX_HOLD=4, req=8'h08 held, done=0.
  - Required: gnt_valid=1 for exactly 4 cycles, then timeout=1 for one cycle, then regrant to 3 one cycle later.
- Simultaneous events:
  - done=1 on the last permitted cycle (hold_cnt=MAX_HOLD-1).
  - Required: release occurs with timeout=0.
  - Separately, drop req[gnt_idx] mid-grant: gnt_valid=0 on the next cycle.
- Reset mid-grant:
  - Assert rst_n=0 while gnt_valid=1 and gnt_idx=4.
  - Required: gnt_valid=0 and gnt_idx=0 immediately, without waiting for a clock edge.
  - After release with req=8'h30, the next grant is 4 (ptr=0 scan).

Source files
------------

// File: rtl/rr_grant_arbiter8.sv
// -----------------------------------------------------------------------------
// rr_grant_arbiter8
//
// Round-robin arbiter for eight requesters. It produces a registered 3-bit
// grant index plus a valid flag. The index feeds a downstream 3-to-8 one-hot
// decoder. A rotating priority pointer provides fairness. A hold limit
// (MAX_HOLD cycles) revokes a grant that is held too long.
//
// Parameters
//   MAX_HOLD     maximum consecutive cycles one grant may stay valid (1..255)
//
// Ports
//   clk          single clock, rising-edge
//   rst_n        asynchronous active-low reset
//   req_i[7:0]   request vector, bit k = requester k
//   done_i       current holder releases; only looked at while granted
//   gnt_idx_o    registered index of the granted requester
//   gnt_valid_o  registered; gnt_idx_o is a live grant
//   timeout_o    one-cycle pulse after a grant is revoked by the hold limit
//
// State  | meaning
// -------+-----------------------------------------------------------------
// IDLE   | no grant; arbitrate req_i from ptr each cycle
// BUSY   | grant live; gnt_idx frozen, hold counter running
// -----------------------------------------------------------------------------
module rr_grant_arbiter8 #(
  parameter int unsigned MAX_HOLD = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] req_i,
  input  logic       done_i,
  output logic [2:0] gnt_idx_o,
  output logic       gnt_valid_o,
  output logic       timeout_o
);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  localparam logic [7:0] HOLD_MAX  = 8'(MAX_HOLD);
  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

  state_e     state_q,     state_d;
  logic [2:0] ptr_q,       ptr_d;
  logic [7:0] hold_cnt_q,  hold_cnt_d;
  logic [2:0] gnt_idx_q,   gnt_idx_d;
  logic       gnt_valid_q, gnt_valid_d;
  logic       timeout_q,   timeout_d;

  logic [2:0] pick_idx;
  logic       holder_req;
  logic       hold_last;

  // First set bit scanning base, base+1, ..., base+7 (mod 8).
  function automatic logic [2:0] rr_pick(input logic [7:0] req,
                                         input logic [2:0] base);
    logic [2:0] idx;
    logic       hit;
    rr_pick = base;
    hit     = 1'b0;
    for (int i = 0; i < 8; i++) begin
      idx = base + 3'(i);
      if (!hit && req[idx]) begin
        rr_pick = idx;
        hit     = 1'b1;
      end
    end
  endfunction

  assign pick_idx   = rr_pick(req_i, ptr_q);
  assign holder_req = req_i[gnt_idx_q];
  assign hold_last  = (hold_cnt_q == HOLD_LAST);

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    hold_cnt_d  = hold_cnt_q;
    gnt_idx_d   = gnt_idx_q;
    gnt_valid_d = gnt_valid_q;
    timeout_d   = 1'b0;

    unique case (state_q)
      IDLE: begin
        gnt_valid_d = 1'b0;
        if (req_i != 8'd0) begin
          gnt_idx_d   = pick_idx;
          gnt_valid_d = 1'b1;
          hold_cnt_d  = 8'd0;
          state_d     = BUSY;
        end
      end

      BUSY: begin
        if (hold_cnt_q != HOLD_MAX) begin
          hold_cnt_d = hold_cnt_q + 8'd1;
        end
        // Release causes in priority order: done, request dropped, hold limit.
        // Only the hold limit, when it is the winning cause, raises timeout.
        if (done_i || !holder_req || hold_last) begin
          ptr_d       = gnt_idx_q + 3'd1;
          gnt_valid_d = 1'b0;
          state_d     = IDLE;
          timeout_d   = !done_i && holder_req && hold_last;
        end
      end

      default: begin
        state_d     = IDLE;
        gnt_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      ptr_q       <= 3'd0;
      hold_cnt_q  <= 8'd0;
      gnt_idx_q   <= 3'd0;
      gnt_valid_q <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      hold_cnt_q  <= hold_cnt_d;
      gnt_idx_q   <= gnt_idx_d;
      gnt_valid_q <= gnt_valid_d;
      timeout_q   <= timeout_d;
    end
  end

  assign gnt_idx_o   = gnt_idx_q;
  assign gnt_valid_o = gnt_valid_q;
  assign timeout_o   = timeout_q;

endmodule

// File: tb/tb_rr_grant_arbiter8.sv
// -----------------------------------------------------------------------------
// tb_rr_grant_arbiter8
//
// Directed bench for rr_grant_arbiter8 with MAX_HOLD=4. Inputs change 1ns
// after each rising edge; outputs are sampled at that same point.
// -----------------------------------------------------------------------------
module tb_rr_grant_arbiter8;

  logic       clk;
  logic       rst_n;
  logic [7:0] req;
  logic       done;
  logic [2:0] gnt_idx;
  logic       gnt_valid;
  logic       timeout;

  int n_total = 0;
  int n_pass  = 0;

  rr_grant_arbiter8 #(.MAX_HOLD(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_i       (req),
    .done_i      (done),
    .gnt_idx_o   (gnt_idx),
    .gnt_valid_o (gnt_valid),
    .timeout_o   (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs,
                       input logic [7:0] exp_v);
    n_total++;
    assert (obs === exp_v) n_pass++;
    else $error("FAIL %s: observed %0d required %0d", tag, obs, exp_v);
  endtask

  task automatic check_out(input string tag, input logic v_exp,
                           input logic [2:0] idx_exp, input logic to_exp);
    check({tag, ".valid"},   8'(gnt_valid), 8'(v_exp));
    check({tag, ".idx"},     8'(gnt_idx),   8'(idx_exp));
    check({tag, ".timeout"}, 8'(timeout),   8'(to_exp));
  endtask

  initial begin
    rst_n = 1'b0;
    req   = 8'h00;
    done  = 1'b0;

    // Reset values
    #12;
    check_out("reset", 1'b0, 3'd0, 1'b0);
    check("reset.ptr", 8'(dut.ptr_q), 8'd0);
    rst_n = 1'b1;
    tick();
    check("idle_noreq.valid", 8'(gnt_valid), 8'd0);

    // Single request 0x20 -> grant 5, then done -> ptr 6
    req = 8'h20;
    tick();
    check_out("single.grant", 1'b1, 3'd5, 1'b0);
    done = 1'b1;
    tick();
    check_out("single.release", 1'b0, 3'd5, 1'b0);
    check("single.ptr", 8'(dut.ptr_q), 8'd6);
    done = 1'b0;
    req  = 8'h00;
    tick();
    check_out("idle_hold", 1'b0, 3'd5, 1'b0);

    // Wrap-around: ptr=6, req=0x21 -> grant 0, then 5
    req = 8'h21;
    tick();
    check_out("wrap.first", 1'b1, 3'd0, 1'b0);
    done = 1'b1;
    tick();
    check("wrap.gap", 8'(gnt_valid), 8'd0);
    check("wrap.ptr", 8'(dut.ptr_q), 8'd1);
    done = 1'b0;
    tick();
    check_out("wrap.second", 1'b1, 3'd5, 1'b0);
    done = 1'b1;
    tick();
    check("wrap.release", 8'(gnt_valid), 8'd0);
    done = 1'b0;
    req  = 8'h00;
    tick();

    // Reset pulse to bring ptr back to 0, then rotation with req=0xFF
    #2 rst_n = 1'b0;
    #2 rst_n = 1'b1;
    req = 8'hFF;
    for (int k = 0; k < 9; k++) begin
      tick();
      check_out($sformatf("rot%0d.grant", k), 1'b1, 3'(k % 8), 1'b0);
      done = 1'b1;
      tick();
      check($sformatf("rot%0d.gap", k), 8'(gnt_valid), 8'd0);
      done = 1'b0;
    end
    req = 8'h00;
    tick();
    check("rot.ptr", 8'(dut.ptr_q), 8'd1);

    // Hold limit: req=0x08 held, no done -> 4 valid cycles, timeout, regrant
    req = 8'h08;
    for (int c = 1; c <= 4; c++) begin
      tick();
      check_out($sformatf("hold.c%0d", c), 1'b1, 3'd3, 1'b0);
    end
    tick();
    check_out("hold.timeout", 1'b0, 3'd3, 1'b1);
    tick();
    check_out("hold.regrant", 1'b1, 3'd3, 1'b0);

    // done on the last permitted cycle: release without timeout
    tick();
    tick();
    tick();
    check("simul.last_cnt", dut.hold_cnt_q, 8'd3);
    check("simul.last_valid", 8'(gnt_valid), 8'd1);
    done = 1'b1;
    tick();
    check_out("simul.done_wins", 1'b0, 3'd3, 1'b0);
    done = 1'b0;

    // Other requests during BUSY do not disturb the grant; drop holder req
    tick();
    check_out("drop.grant", 1'b1, 3'd3, 1'b0);
    req = 8'h09;
    tick();
    check_out("drop.other_req", 1'b1, 3'd3, 1'b0);
    req = 8'h00;
    tick();
    check_out("drop.release", 1'b0, 3'd3, 1'b0);
    tick();
    check("drop.ptr", 8'(dut.ptr_q), 8'd4);

    // Reset mid-grant with gnt_idx=4
    req = 8'h10;
    tick();
    check_out("midrst.grant", 1'b1, 3'd4, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check_out("midrst.async", 1'b0, 3'd0, 1'b0);
    req = 8'h30;
    #3 rst_n = 1'b1;
    tick();
    check_out("midrst.after", 1'b1, 3'd4, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
